// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogram sequencer producing the control-ROM address
// Supports conditional branching on ALU flags, opcode mapping and a return-address stack.
module micro_sequencer #(
  parameter int CAR_WIDTH    = 10,
  parameter int OPCODE_WIDTH = 8,
  parameter int MAP_OFFSET   = 4,
  parameter int FETCH_ADDR   = 0,
  parameter int STACK_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            hlt,
  input  logic [2:0]                      seq_op,
  input  logic [2:0]                      cond_sel,
  input  logic                            cond_pol,
  input  logic [CAR_WIDTH-1:0]            branch_addr,
  input  logic [OPCODE_WIDTH-1:0]         opcode,
  input  logic                            ir_valid,
  input  logic [3:0]                      flags,
  output logic [CAR_WIDTH-1:0]            car,
  output logic [$clog2(STACK_DEPTH):0]    sp,
  output logic                            halted,
  output logic                            stack_ovf,
  output logic                            stack_unf
);

  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int SUM_W = ((OPCODE_WIDTH > CAR_WIDTH) ? OPCODE_WIDTH : CAR_WIDTH) + 1;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_MAP    = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5,
    OP_FETCH  = 3'd6,
    OP_HOLD   = 3'd7
  } seq_op_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CAR_WIDTH-1:0]   car_q, car_d;
  logic [SP_W-1:0]        sp_q, sp_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic [CAR_WIDTH-1:0]   stack_q [STACK_DEPTH];

  logic [CAR_WIDTH-1:0]   next_addr;
  logic [SUM_W-1:0]       map_sum;
  logic [PTR_W-1:0]       push_idx;
  logic [PTR_W-1:0]       pop_idx;
  logic                   push_en;
  logic                   cond_raw;
  logic                   cond;

  assign next_addr = car_q + 1'b1;
  assign map_sum   = SUM_W'(opcode) + SUM_W'(MAP_OFFSET);
  assign push_idx  = sp_q[PTR_W-1:0];
  assign pop_idx   = PTR_W'(sp_q - 1'b1);

  always_comb begin
    cond_raw = 1'b0;
    case (cond_sel)
      3'd0:    cond_raw = 1'b1;
      3'd1:    cond_raw = flags[3];
      3'd2:    cond_raw = flags[2];
      3'd3:    cond_raw = flags[1];
      3'd4:    cond_raw = flags[0];
      default: cond_raw = 1'b0;
    endcase
    cond = cond_raw ^ cond_pol;
  end

  always_comb begin
    state_d = state_q;
    car_d   = car_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A halt request suppresses the operation sampled on the same edge.
        if (hlt) begin
          state_d = ST_HALTED;
        end else begin
          case (seq_op_e'(seq_op))
            OP_NEXT:   car_d = next_addr;
            OP_JUMP:   car_d = branch_addr;
            OP_BRANCH: car_d = cond ? branch_addr : next_addr;
            OP_MAP:    if (ir_valid) car_d = map_sum[CAR_WIDTH-1:0];
            OP_CALL: begin
              car_d = branch_addr;
              if (sp_q == SP_W'(STACK_DEPTH)) begin
                ovf_d = 1'b1;
              end else begin
                push_en = 1'b1;
                sp_d    = sp_q + 1'b1;
              end
            end
            OP_RET: begin
              if (sp_q == '0) begin
                unf_d = 1'b1;
                car_d = CAR_WIDTH'(FETCH_ADDR);
              end else begin
                car_d = stack_q[pop_idx];
                sp_d  = sp_q - 1'b1;
              end
            end
            OP_FETCH:  car_d = CAR_WIDTH'(FETCH_ADDR);
            default:   car_d = car_q;
          endcase
        end
      end
      default: begin
        if (!hlt) state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      car_q   <= CAR_WIDTH'(FETCH_ADDR);
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      car_q   <= car_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage is not reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= next_addr;
  end

  assign car       = car_q;
  assign sp        = sp_q;
  assign halted    = (state_q == ST_HALTED);
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule
